// File: rtl/ad_ip_jesd204_tpl_dac_framer.sv
// ad_ip_jesd204_tpl_dac_framer: JESD204 TX transport framer with per-channel source select and format conversion
// PN7/PN15 generators are built only when TPL_DAC_PN_EN is defined; otherwise src 2/3 send zeros.
module ad_ip_jesd204_tpl_dac_framer #(
  parameter int NUM_LANES = 2,
  parameter int NUM_CHANNELS = 2,
  parameter int OCTETS_PER_BEAT = 4
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_CHANNELS*2-1:0]             src_sel,
  input  logic [NUM_CHANNELS-1:0]               dfmt_type,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [OCTETS_PER_BEAT*8*NUM_LANES-1:0] s_data,
  input  logic                                  link_ready,
  output logic                                  link_valid,
  output logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0] link_data,
  output logic                                  dunf,
  output logic [15:0]                           dunf_count,
  input  logic                                  dunf_clr
);
  localparam int DPW = OCTETS_PER_BEAT*8*NUM_LANES/NUM_CHANNELS/16;
  localparam int F = 2*NUM_CHANNELS/NUM_LANES;
  localparam int BW = NUM_LANES*OCTETS_PER_BEAT*8;

  logic          dma_used;
  logic          underflow;
  logic [15:0]   smp [NUM_CHANNELS][DPW];
  logic [15:0]   pn_smp [NUM_CHANNELS][DPW];
  logic [BW-1:0] beat;

  always_comb begin
    dma_used = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) dma_used = dma_used | (src_sel[2*c +: 2] == 2'd0);
  end

  assign s_ready   = link_ready & dma_used;
  assign underflow = link_ready & dma_used & ~s_valid;

`ifdef TPL_DAC_PN_EN
  logic [6:0]  pn7_q [NUM_CHANNELS];
  logic [6:0]  pn7_d [NUM_CHANNELS];
  logic [14:0] pn15_q [NUM_CHANNELS];
  logic [14:0] pn15_d [NUM_CHANNELS];
  logic [15:0] pn7_smp [NUM_CHANNELS][DPW];
  logic [15:0] pn15_smp [NUM_CHANNELS][DPW];

  // Each call emits the next 16 LFSR output bits, oldest in the MSB.
  function automatic logic [22:0] pn7_step(input logic [6:0] s);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o = {o[14:0], s[6] ^ s[5]};
      s = {s[5:0], s[6] ^ s[5]};
    end
    return {s, o};
  endfunction

  function automatic logic [30:0] pn15_step(input logic [14:0] s);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o = {o[14:0], s[14] ^ s[13]};
      s = {s[13:0], s[14] ^ s[13]};
    end
    return {s, o};
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pn7_d[c] = pn7_q[c];
      pn15_d[c] = pn15_q[c];
      for (int j = 0; j < DPW; j++) begin
        {pn7_d[c], pn7_smp[c][j]} = pn7_step(pn7_d[c]);
        {pn15_d[c], pn15_smp[c][j]} = pn15_step(pn15_d[c]);
        pn_smp[c][j] = src_sel[2*c +: 2] == 2'd2 ? pn7_smp[c][j] :
                       src_sel[2*c +: 2] == 2'd3 ? pn15_smp[c][j] : 16'd0;
      end
      if (src_sel[2*c +: 2] != 2'd2) pn7_d[c] = 7'h7f;
      if (src_sel[2*c +: 2] != 2'd3) pn15_d[c] = 15'h7fff;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        pn7_q[c] <= 7'h7f;
        pn15_q[c] <= 15'h7fff;
      end
    end else if (link_ready) begin
      pn7_q <= pn7_d;
      pn15_q <= pn15_d;
    end
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      for (int j = 0; j < DPW; j++) pn_smp[c][j] = 16'd0;
  end
`endif

  // Underflow zeros bypass the format conversion since s_valid gates the XOR as well.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      for (int j = 0; j < DPW; j++)
        smp[c][j] = src_sel[2*c +: 2] != 2'd0 ? pn_smp[c][j] :
                    s_valid ? s_data[(c*DPW+j)*16 +: 16] ^ {dfmt_type[c], 15'd0} : 16'd0;
  end

  always_comb begin
    beat = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int j = 0; j < DPW; j++)
        for (int i = 0; i < F; i++)
          beat[(l*OCTETS_PER_BEAT + j*F + i)*8 +: 8] = smp[(l*F+i)/2][j][8*(1-(l*F+i)%2) +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      link_valid <= 1'b0;
      link_data <= '0;
      dunf <= 1'b0;
      dunf_count <= '0;
    end else begin
      dunf <= underflow;
      dunf_count <= dunf_clr ? {15'd0, underflow} : dunf_count + {15'd0, underflow & ~&dunf_count};
      if (link_ready) begin
        link_valid <= 1'b1;
        link_data <= beat;
      end
    end
  end
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_framer.sv
// tb_ad_ip_jesd204_tpl_dac_framer: directed and random checks of the DAC framer against a bit-sequence reference model
module tb_ad_ip_jesd204_tpl_dac_framer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  src_sel = '0;
  logic [1:0]  dfmt_type = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        link_ready = 1'b0;
  logic        link_valid;
  logic [63:0] link_data;
  logic        dunf;
  logic [15:0] dunf_count;
  logic        dunf_clr = 1'b0;

  ad_ip_jesd204_tpl_dac_framer dut (
    .clk(clk), .resetn(resetn), .src_sel(src_sel), .dfmt_type(dfmt_type),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .link_ready(link_ready),
    .link_valid(link_valid), .link_data(link_data), .dunf(dunf),
    .dunf_count(dunf_count), .dunf_clr(dunf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit x7 [134];
  bit x15 [32782];
  int pos7 [2];
  int pos15 [2];
  logic [63:0] exp_data;
  logic        exp_valid;
  logic        exp_dunf;
  logic [15:0] exp_cnt;
  logic [63:0] saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output bit n of each PN sequence; the seed supplies the bits before n=0.
  function automatic logic [15:0] pn_word(input bit is15, input int start);
    logic [15:0] v;
    v = '0;
    for (int b = 0; b < 16; b++)
      v = {v[14:0], is15 ? x15[(start + b) % 32767 + 15] : x7[(start + b) % 127 + 7]};
    return v;
  endfunction

  function automatic logic [15:0] exp_sample(input int c, input int j);
    logic [1:0] sel;
    sel = src_sel[2*c +: 2];
    if (sel == 2'd0) return s_valid ? s_data[(c*2+j)*16 +: 16] ^ (dfmt_type[c] ? 16'h8000 : 16'h0000) : 16'h0000;
`ifdef TPL_DAC_PN_EN
    if (sel == 2'd2) return pn_word(1'b0, pos7[c] + 16*j);
    if (sel == 2'd3) return pn_word(1'b1, pos15[c] + 16*j);
`endif
    return 16'h0000;
  endfunction

  function automatic logic [63:0] build_beat();
    logic [63:0] r;
    logic [15:0] s;
    int o;
    r = '0;
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 4; k++) begin
        o = l*2 + k%2;
        s = exp_sample(o/2, k/2);
        r[(l*4+k)*8 +: 8] = (o % 2 == 0) ? s[15:8] : s[7:0];
      end
    return r;
  endfunction

  task automatic model_reset();
    exp_data = '0;
    exp_valid = 1'b0;
    exp_dunf = 1'b0;
    exp_cnt = '0;
    for (int c = 0; c < 2; c++) begin
      pos7[c] = 0;
      pos15[c] = 0;
    end
  endtask

  // Inputs are set at a falling edge; this checks s_ready, clocks once, then checks the registered outputs.
  task automatic cycle();
    logic dma, uf;
    #1;
    dma = (src_sel[1:0] == 2'd0) || (src_sel[3:2] == 2'd0);
    uf = link_ready & dma & ~s_valid;
    chk("s_ready", s_ready, link_ready & dma);
    if (link_ready) begin
      exp_data = build_beat();
      exp_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
        pos7[c] = src_sel[2*c +: 2] == 2'd2 ? (pos7[c] + 32) % 127 : 0;
        pos15[c] = src_sel[2*c +: 2] == 2'd3 ? (pos15[c] + 32) % 32767 : 0;
      end
    end
    exp_dunf = uf;
    if (dunf_clr) exp_cnt = {15'd0, uf};
    else if (uf && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    @(negedge clk);
    chk("link_data", link_data, exp_data);
    chk("link_valid", link_valid, exp_valid);
    chk("dunf", dunf, exp_dunf);
    chk("dunf_count", dunf_count, exp_cnt);
  endtask

  initial begin
    for (int n = 0; n < 7; n++) x7[n] = 1'b1;
    for (int n = 7; n < 134; n++) x7[n] = x7[n-7] ^ x7[n-6];
    for (int n = 0; n < 15; n++) x15[n] = 1'b1;
    for (int n = 15; n < 32782; n++) x15[n] = x15[n-15] ^ x15[n-14];
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", link_valid, 1'b0);
    chk("rst_data", link_data, 64'd0);
    chk("rst_dunf", dunf, 1'b0);
    chk("rst_count", dunf_count, 16'd0);
    resetn = 1'b1;

    src_sel = 4'b0000; dfmt_type = 2'b00; s_valid = 1'b1; link_ready = 1'b1;
    s_data = {16'hEF01, 16'hABCD, 16'h5678, 16'h1234};
    cycle();
    chk("pack_literal", link_data, 64'h01EFCDAB_78563412);
    dfmt_type = 2'b01;
    cycle();
    chk("offset_literal", link_data, 64'h01EFCDAB_78D63492);

    dfmt_type = 2'b00; src_sel = 4'b0100; s_valid = 1'b0;
    repeat (3) cycle();
    chk("unf_count3", dunf_count, 16'd3);
    chk("unf_zero", link_data, 64'd0);
    dunf_clr = 1'b1;
    cycle();
    chk("unf_clr_count", dunf_count, 16'd1);
    dunf_clr = 1'b0;

    s_valid = 1'b1; link_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_data = {$urandom, $urandom};
      cycle();
    end
    chk("bp_data", link_data, 64'd0);
    chk("bp_count", dunf_count, 16'd1);

    link_ready = 1'b1; s_valid = 1'b0; src_sel = 4'b0110;
    cycle();
    saved = link_data;
    repeat (99) cycle();
    src_sel = 4'b0100; s_valid = 1'b1; s_data = {$urandom, $urandom};
    cycle();
    src_sel = 4'b0110; s_valid = 1'b0;
    cycle();
    chk("pn_restart", link_data, saved);
    repeat (3) cycle();

    for (int i = 0; i < 400; i++) begin
      src_sel = 4'(($urandom_range(0, 7) >> 1) | (($urandom_range(0, 7) >> 1) << 2)) & 4'hf;
      if ($urandom_range(0, 3) == 0) src_sel = 4'($urandom_range(0, 15));
      dfmt_type = 2'($urandom_range(0, 3));
      s_valid = $urandom_range(0, 3) != 0;
      link_ready = $urandom_range(0, 3) != 0;
      dunf_clr = $urandom_range(0, 15) == 0;
      s_data = {$urandom, $urandom};
      cycle();
    end
    dunf_clr = 1'b0;

    src_sel = 4'b0000; s_valid = 1'b0; link_ready = 1'b1;
    cycle();
    s_valid = 1'b1; s_data = {$urandom, $urandom};
    cycle();
    #2 resetn = 1'b0;
    #1;
    chk("midrst_valid", link_valid, 1'b0);
    chk("midrst_data", link_data, 64'd0);
    chk("midrst_count", dunf_count, 16'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    src_sel = 4'b1011;
    repeat (4) cycle();
    src_sel = 4'b0000;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
